// File: rtl/divisor_top_if.sv
// Handshake and operand/result bundle for the restoring divider.
// The master side issues start with A/B; the slave side returns Q/R and status.
interface divisor_top_if #(
    parameter int N = 4
);
    logic         start;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic [N-1:0] Q;
    logic [N-1:0] R;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output start, A, B,
        input  Q, R, busy, done, div_by_zero
    );

    modport slave (
        input  start, A, B,
        output Q, R, busy, done, div_by_zero
    );
endinterface

// File: rtl/divisor_top.sv
// Unsigned N-bit restoring divider producing one quotient bit per clock.
// A start pulse captures A/B; N+1 clocks later Q/R/div_by_zero update with a done pulse.
module divisor_top #(
    parameter int N = 4
) (
    input  logic              clk,
    input  logic              rst,
    divisor_top_if.slave      bus
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_ITER = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FINISH
    } state_t;

    state_t        state_q;
    state_t        state_d;

    logic [CW-1:0] cnt_q;
    logic [N-1:0]  dvd_q;
    logic [N-1:0]  dvs_q;
    logic [N-1:0]  quo_q;
    logic [N-1:0]  rem_q;
    logic [N:0]    step;

    logic [N-1:0]  q_q;
    logic [N-1:0]  r_q;
    logic          done_q;
    logic          dbz_q;

    // One restoring iteration: returns {quotient bit, next partial remainder}.
    // The trial remainder is N+1 bits wide so the compare against B never overflows;
    // after a successful subtract it is always below B, so N bits suffice to store it.
    function automatic logic [N:0] restore_step(
        input logic [N-1:0] rem,
        input logic         din,
        input logic [N-1:0] dvs
    );
        logic [N:0] trial;
        logic [N:0] diff;
        trial = {rem, din};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            restore_step = {1'b1, diff[N-1:0]};
        end else begin
            restore_step = {1'b0, trial[N-1:0]};
        end
    endfunction

    always_comb begin
        step = restore_step(rem_q, dvd_q[N-1], dvs_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == LAST_ITER) state_d = FINISH;
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            dvd_q  <= '0;
            dvs_q  <= '0;
            quo_q  <= '0;
            rem_q  <= '0;
            q_q    <= '0;
            r_q    <= '0;
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        dvd_q <= bus.A;
                        dvs_q <= bus.B;
                        rem_q <= '0;
                        quo_q <= '0;
                        cnt_q <= '0;
                    end
                end
                RUN: begin
                    // B==0 falls out naturally: every compare succeeds, Q saturates, R collects A.
                    rem_q <= step[N-1:0];
                    quo_q <= {quo_q[N-2:0], step[N]};
                    dvd_q <= {dvd_q[N-2:0], 1'b0};
                    cnt_q <= cnt_q + 1'b1;
                end
                FINISH: begin
                    q_q    <= quo_q;
                    r_q    <= rem_q;
                    dbz_q  <= (dvs_q == '0);
                    done_q <= 1'b1;
                end
                default: begin
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.Q           = q_q;
    assign bus.R           = r_q;
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.busy        = (state_q != IDLE);

endmodule

// File: tb/tb_divisor_top.sv
// Self-checking bench for divisor_top: directed vector table, hand-written
// corner sequences, exhaustive back-to-back sweep and randomized runs.
module tb_divisor_top;
    localparam int N   = 4;
    localparam int LAT = N + 1;
    localparam int MAXV = (1 << N) - 1;

    logic clk;
    logic rst;
    int   total;
    int   passed;
    int   done_pulses;

    divisor_top_if #(.N(N)) dif ();

    divisor_top #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial done_pulses = 0;
    always @(posedge clk) begin
        if (dif.done === 1'b1) done_pulses <= done_pulses + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int a;
        int b;
        int q;
        int r;
        int dbz;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference behaviour in plain integer arithmetic.
    task automatic ref_div(input int a, input int b, output int q, output int r, output int dbz);
        if (b == 0) begin
            q = MAXV; r = a; dbz = 1;
        end else begin
            q = a / b; r = a % b; dbz = 0;
        end
    endtask

    // Called at #1 after an edge with the DUT idle; returns at #1 after the done edge.
    task automatic run_div(input int a, input int b, input bit scramble,
                           output int q, output int r, output int dbz,
                           output int lat, output int busy_run);
        dif.start = 1'b1;
        dif.A     = N'(a);
        dif.B     = N'(b);
        @(posedge clk); #1;
        dif.start = 1'b0;
        busy_run  = int'(dif.busy);
        lat = 0;
        while (dif.done !== 1'b1 && lat < 20) begin
            if (scramble) begin
                dif.A = N'($urandom);
                dif.B = N'($urandom);
            end
            @(posedge clk); #1;
            lat++;
        end
        q   = int'(dif.Q);
        r   = int'(dif.R);
        dbz = int'(dif.div_by_zero);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int q, r, dbz, lat, busy_run;
        int eq, er, edbz;
        int snap;

        total  = 0;
        passed = 0;
        vecs[0] = '{a: 13, b: 4, q: 3,  r: 1, dbz: 0};
        vecs[1] = '{a: 15, b: 1, q: 15, r: 0, dbz: 0};
        vecs[2] = '{a: 3,  b: 7, q: 0,  r: 3, dbz: 0};
        vecs[3] = '{a: 0,  b: 5, q: 0,  r: 0, dbz: 0};
        vecs[4] = '{a: 9,  b: 0, q: 15, r: 9, dbz: 1};
        vecs[5] = '{a: 8,  b: 2, q: 4,  r: 0, dbz: 0};

        rst = 1'b1;
        dif.start = 1'b0;
        dif.A = '0;
        dif.B = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_Q", int'(dif.Q), 0);
        chk("reset_R", int'(dif.R), 0);
        chk("reset_busy", int'(dif.busy), 0);
        chk("reset_done", int'(dif.done), 0);
        chk("reset_dbz", int'(dif.div_by_zero), 0);
        rst = 1'b0;
        idle_cycles(2);

        // Directed table
        for (int i = 0; i < 6; i++) begin
            run_div(vecs[i].a, vecs[i].b, 1'b0, q, r, dbz, lat, busy_run);
            chk($sformatf("vec%0d_Q", i), q, vecs[i].q);
            chk($sformatf("vec%0d_R", i), r, vecs[i].r);
            chk($sformatf("vec%0d_dbz", i), dbz, vecs[i].dbz);
            chk($sformatf("vec%0d_latency", i), lat, LAT);
            chk($sformatf("vec%0d_busy_run", i), busy_run, 1);
            chk($sformatf("vec%0d_busy_done", i), int'(dif.busy), 0);
            idle_cycles(1);
            chk($sformatf("vec%0d_done_pulse_len", i), int'(dif.done), 0);
            chk($sformatf("vec%0d_Q_hold", i), int'(dif.Q), vecs[i].q);
            idle_cycles(1);
        end

        // Second start while busy is ignored and not queued
        snap = done_pulses;
        dif.start = 1'b1; dif.A = 4'd12; dif.B = 4'd5;
        @(posedge clk); #1;
        dif.start = 1'b0;
        @(posedge clk); #1;
        dif.start = 1'b1; dif.A = 4'd7; dif.B = 4'd7;
        @(posedge clk); #1;
        dif.start = 1'b0;
        lat = 2;
        while (dif.done !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("busy_start_latency", lat, LAT);
        chk("busy_start_Q", int'(dif.Q), 2);
        chk("busy_start_R", int'(dif.R), 2);
        idle_cycles(12);
        chk("busy_start_busy_after", int'(dif.busy), 0);
        chk("busy_start_done_count", done_pulses - snap, 1);

        // Reset during the second RUN cycle aborts the division
        snap = done_pulses;
        dif.start = 1'b1; dif.A = 4'd14; dif.B = 4'd3;
        @(posedge clk); #1;
        dif.start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_Q", int'(dif.Q), 0);
        chk("abort_R", int'(dif.R), 0);
        chk("abort_busy", int'(dif.busy), 0);
        idle_cycles(10);
        chk("abort_done_count", done_pulses - snap, 0);
        chk("abort_busy_later", int'(dif.busy), 0);

        // Exhaustive sweep, each start issued in the done cycle of the previous one
        snap = done_pulses;
        for (int a = 0; a <= MAXV; a++) begin
            for (int b = 0; b <= MAXV; b++) begin
                run_div(a, b, 1'b0, q, r, dbz, lat, busy_run);
                ref_div(a, b, eq, er, edbz);
                chk($sformatf("exh_%0d_%0d_Q", a, b), q, eq);
                chk($sformatf("exh_%0d_%0d_R", a, b), r, er);
                chk($sformatf("exh_%0d_%0d_dbz", a, b), dbz, edbz);
                chk($sformatf("exh_%0d_%0d_lat", a, b), lat, LAT);
            end
        end
        idle_cycles(2);
        chk("exh_done_count", done_pulses - snap, (MAXV + 1) * (MAXV + 1));

        // Randomized operands, random idle gaps, inputs wiggled while busy
        for (int i = 0; i < 64; i++) begin
            int a, b;
            a = int'($urandom_range(0, MAXV));
            b = int'($urandom_range(0, MAXV));
            run_div(a, b, 1'b1, q, r, dbz, lat, busy_run);
            ref_div(a, b, eq, er, edbz);
            chk($sformatf("rnd%0d_Q", i), q, eq);
            chk($sformatf("rnd%0d_R", i), r, er);
            chk($sformatf("rnd%0d_dbz", i), dbz, edbz);
            chk($sformatf("rnd%0d_lat", i), lat, LAT);
            idle_cycles(int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
